wolfram_ca_engine: RTL and testbench
====================================

WOLFRAM_CA_ENGINE -- requirements
Module: wolfram_ca_engine

Interface
REQ-001 Parameter WIDTH, default 16, number of cells in the automaton register (minimum 3).
REQ-002 Parameter CNT_W, default 8, width of the step counter and the steps input.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rule  input  8  truth table of the 3-input next-state function; sampled on start.
REQ-006 load  input  1  seed load strobe; honoured only in IDLE.
REQ-007 seed  input  WIDTH  initial cell values, captured on load.
REQ-008 start  input  1  begin evolution; honoured only in IDLE.
REQ-009 steps  input  CNT_W  number of generations to compute; sampled on start.
REQ-010 state_out  output  WIDTH  current cell register.
REQ-011 gen_count  output  CNT_W  generations computed since the last start.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse on the cycle the FSM enters DONE.

Function
REQ-014 FSM states are IDLE, RUN and DONE; transitions are IDLE->RUN on start, RUN->DONE when gen_count equals the latched steps, and DONE->IDLE unconditionally after one cycle.
REQ-015 Cell i neighbourhood: p = {left=s[i+1], centre=s[i], right=s[i-1]}, with left as MSB; next s[i] = rule[7-p].
REQ-016 This encoding makes rule 8'h3D map patterns 000..111 to 0,0,1,1,1,1,0,1.
REQ-017 All cells update simultaneously once per clock in RUN, computing one generation per cycle, and gen_count increments with each generation.
REQ-018 On start the block latches rule and steps, clears gen_count, and enters RUN.
REQ-019 If start arrives with steps=0, the FSM enters RUN, makes no cell update, moves to DONE on the next cycle, and pulses done.
REQ-020 Latency is steps+2 cycles from the start edge to the done pulse, with busy high for steps+1 cycles.
REQ-021 load in IDLE copies seed into the cell register on the next edge.
REQ-022 If load and start are asserted together in IDLE, load wins and start is ignored.
REQ-023 load and start are ignored in RUN and DONE, and changes to rule or steps during RUN have no effect.
REQ-024 gen_count holds its final value through DONE and IDLE until the next start.
REQ-025 The rule and steps latches are internal; state_out reflects the register directly with no extra output delay.

Reset
REQ-026 When rst_n is low, the cell register, gen_count, the rule latch and the steps latch clear to 0, the FSM goes to IDLE, and busy and done drive 0.
REQ-027 Asserting rst_n during RUN aborts evolution immediately without any done pulse, and the first honoured command after release is load or start in IDLE.

Configuration
REQ-028 Macro WOLFRAM_CA_WRAP_EN selects the boundary condition.
REQ-029 With WOLFRAM_CA_WRAP_EN defined, boundaries are periodic: s[WIDTH] reads s[0] and s[-1] reads s[WIDTH-1].
REQ-030 Without WOLFRAM_CA_WRAP_EN, boundaries are fixed: s[WIDTH] and s[-1] read constant 0.

Verification
REQ-031 WIDTH=8, WRAP_EN off: load seed 8'h01, start with rule 8'h3D and steps=1 -> state_out=8'h01, gen_count=1, and done pulses 3 cycles after start.
REQ-032 WIDTH=8, WRAP_EN on: same stimulus as REQ-031 -> state_out=8'h81.
REQ-033 WIDTH=8: rule 8'h0F (next=left), seed 8'h01, steps=1 -> state_out=8'h80 with WRAP_EN on and 8'h00 with WRAP_EN off; with WRAP_EN on and steps=8, state_out returns to 8'h01.
REQ-034 Rule 8'h33 (identity) with steps=0 -> no state change, busy high for 1 cycle, done pulses, and gen_count=0.
REQ-035 Load and start asserted in the same IDLE cycle -> seed is captured, busy stays 0, and no done pulse occurs.
REQ-036 Drop rst_n mid-run at gen_count=3 of steps=10 -> all outputs read 0 and the FSM is in IDLE with no done pulse; a subsequent load and start completes normally.

Source files
------------

// File: rtl/wolfram_ca_engine.sv
// One-dimensional elementary cellular automaton that evolves WIDTH cells for a programmable number of generations.
// Build option: define WOLFRAM_CA_WRAP_EN for periodic boundaries; fixed zero boundaries otherwise.
module wolfram_ca_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rule,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] state_out,
  output logic [CNT_W-1:0] gen_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cells;
  logic [CNT_W-1:0] r_gen;
  logic [CNT_W-1:0] r_steps;
  logic [7:0]       r_rule;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH+1:0] w_ext;
  logic [WIDTH-1:0] w_next;

  // Neighbourhood pattern p = {left, centre, right} selects bit 7-p of the rule.
  function automatic logic rule_lookup(input logic [7:0] r, input logic [2:0] p);
    rule_lookup = r[3'd7 - p];
  endfunction

  // Boundary cells: w_ext[WIDTH+1] is s[WIDTH], w_ext[0] is s[-1].
`ifdef WOLFRAM_CA_WRAP_EN
  assign w_ext = {r_cells[0], r_cells, r_cells[WIDTH-1]};
`else
  assign w_ext = {1'b0, r_cells, 1'b0};
`endif

  // Next generation for every cell in parallel.
  always_comb begin
    w_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_next[i] = rule_lookup(r_rule, w_ext[i+2 -: 3]);
    end
  end

  // Control FSM with registered busy/done; cells and counters update here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cells <= '0;
      r_gen   <= '0;
      r_steps <= '0;
      r_rule  <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (load) begin
            r_cells <= seed;
          end else if (start) begin
            r_rule  <= rule;
            r_steps <= steps;
            r_gen   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          // Termination is checked before updating, so steps=0 makes no change.
          if (r_gen == r_steps) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cells <= w_next;
            r_gen   <= r_gen + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign state_out = r_cells;
  assign gen_count = r_gen;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Directed table-driven bench for wolfram_ca_engine at WIDTH=8; expectations follow WOLFRAM_CA_WRAP_EN.
module tb_wolfram_ca_engine;

  logic       clk;
  logic       rst_n;
  logic [7:0] rule;
  logic       load;
  logic [7:0] seed;
  logic       start;
  logic [7:0] steps;
  logic [7:0] state_out;
  logic [7:0] gen_count;
  logic       busy;
  logic       done;

  int n_pass;
  int n_total;

  wolfram_ca_engine #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rule(rule), .load(load), .seed(seed),
    .start(start), .steps(steps), .state_out(state_out),
    .gen_count(gen_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seed;
    logic [7:0] rule;
    logic [7:0] steps;
    logic       poke;
    logic [7:0] exp_fixed;
    logic [7:0] exp_wrap;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_load(input logic [7:0] s);
    @(negedge clk);
    seed = s;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Issue start, scramble rule/steps afterwards, optionally poke load/start during RUN.
  task automatic do_run(input logic [7:0] r, input logic [7:0] n, input logic poke,
                        output int lat, output int busy_cyc, output logic timed_out);
    @(negedge clk);
    rule  = r;
    steps = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rule  = ~r;
    steps = 8'hFF;
    lat = 1;
    busy_cyc = 0;
    timed_out = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (busy) busy_cyc++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (k == 0 && poke) begin
        load  = 1'b1;
        start = 1'b1;
        seed  = 8'h00;
      end else begin
        load  = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    load  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int bc;
    logic to;
    logic [7:0] exp_s;
    logic seen;

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    rule = 8'h00; load = 1'b0; seed = 8'h00; start = 1'b0; steps = 8'h00;

    //        seed   rule   steps poke  fixed  wrap
    vecs[0] = '{8'h01, 8'h3D, 8'd1, 1'b0, 8'h01, 8'h81};
    vecs[1] = '{8'h01, 8'h0F, 8'd1, 1'b0, 8'h00, 8'h80};
    vecs[2] = '{8'h01, 8'h0F, 8'd8, 1'b0, 8'h00, 8'h01};
    vecs[3] = '{8'hA5, 8'h33, 8'd0, 1'b0, 8'hA5, 8'hA5};
    vecs[4] = '{8'h80, 8'hF0, 8'd1, 1'b1, 8'hBF, 8'hBF};
    vecs[5] = '{8'h10, 8'h5A, 8'd2, 1'b1, 8'h44, 8'h44};
    vecs[6] = '{8'hFF, 8'h5A, 8'd1, 1'b0, 8'h81, 8'h00};

    #1;
    check("reset_state", {24'h0, state_out}, 32'h0);
    check("reset_gen", {24'h0, gen_count}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
`ifdef WOLFRAM_CA_WRAP_EN
      exp_s = vecs[v].exp_wrap;
`else
      exp_s = vecs[v].exp_fixed;
`endif
      do_load(vecs[v].seed);
      check($sformatf("v%0d_seed", v), {24'h0, state_out}, {24'h0, vecs[v].seed});
      do_run(vecs[v].rule, vecs[v].steps, vecs[v].poke, lat, bc, to);
      check($sformatf("v%0d_timeout", v), {31'h0, to}, 32'h0);
      check($sformatf("v%0d_state", v), {24'h0, state_out}, {24'h0, exp_s});
      check($sformatf("v%0d_gen", v), {24'h0, gen_count}, {24'h0, vecs[v].steps});
      check($sformatf("v%0d_latency", v), lat, 32'(vecs[v].steps) + 32'd2);
      check($sformatf("v%0d_busy_cycles", v), bc, 32'(vecs[v].steps) + 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), {31'h0, done}, 32'h0);
      check($sformatf("v%0d_gen_hold", v), {24'h0, gen_count}, {24'h0, vecs[v].steps});
    end

    // Load and start together: load wins, no run begins.
    @(negedge clk);
    seed = 8'h3C; load = 1'b1; start = 1'b1; rule = 8'h00; steps = 8'd5;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check("ls_state", {24'h0, state_out}, 32'h3C);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (busy || done) seen = 1'b1;
      @(negedge clk);
    end
    check("ls_no_activity", {31'h0, seen}, 32'h0);
    check("ls_gen_kept", {24'h0, gen_count}, 32'h1);

    // Reset mid-run at gen_count=3 of 10.
    do_load(8'h01);
    @(negedge clk);
    rule = 8'h5A; steps = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (gen_count == 8'd3) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("mid_reach_gen3", {31'h0, to}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {24'h0, state_out}, 32'h0);
    check("mid_rst_gen", {24'h0, gen_count}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy || done) seen = 1'b1;
      @(negedge clk);
    end
    check("mid_idle_after", {31'h0, seen}, 32'h0);
    do_load(8'h01);
    do_run(8'h3D, 8'd1, 1'b0, lat, bc, to);
    check("post_timeout", {31'h0, to}, 32'h0);
`ifdef WOLFRAM_CA_WRAP_EN
    check("post_state", {24'h0, state_out}, 32'h81);
`else
    check("post_state", {24'h0, state_out}, 32'h01);
`endif
    check("post_gen", {24'h0, gen_count}, 32'h1);
    check("post_latency", lat, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
